// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer
//   Iterative divide/remainder unit for the RV32IM EX stage (DIV, DIVU, REM, REMU).
//   When EX presents a divide op, the unit latches the operand magnitudes and sign
//   flags, then runs a radix-2 restoring divider for XLEN cycles. It stalls IF/ID/EX
//   until the result is ready. Divide-by-zero and signed overflow are resolved
//   without iterating.
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           asynchronous reset, active low
//   start         EX holds a divide op; held high while stalled
//   flush         synchronous kill of the EX instruction
//   op            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend      rs1 value after forwarding
//   divisor       rs2 value after forwarding
//   stall         hold the pipeline registers upstream of EX/MEM
//   busy          FSM is not IDLE
//   result_valid  result is valid this cycle
//   result        quotient or remainder, selected by the latched op
module ex_div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            rem_sel_q;   // op[1] of the latched op: 1 selects remainder
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;

  // Two's-complement negate, used for both magnitude and sign fix-up.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v,
                                                  input logic            neg);
    return neg ? negate(v) : v;
  endfunction

  // Operand decode in IDLE.
  logic            op_signed;
  logic signed [XLEN-1:0] dvd_s;
  logic signed [XLEN-1:0] dvs_s;
  logic            dvd_neg;
  logic            dvs_neg;
  logic            div_zero;
  logic            sgn_ovf;

  assign op_signed = ~op[0];
  assign dvd_s     = dividend;
  assign dvs_s     = divisor;
  assign dvd_neg   = op_signed & (dvd_s < 0);
  assign dvs_neg   = op_signed & (dvs_s < 0);
  assign div_zero  = (divisor == '0);
  assign sgn_ovf   = op_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // One restoring step. The shifted partial remainder needs XLEN+1 bits because it
  // can reach 2*divisor-1; the trial's top bit is the borrow (negative result).
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic            step_ok;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign step_ok = ~trial[XLEN];
  assign rem_nxt = step_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt = {quo_q[XLEN-2:0], step_ok};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            rem_sel_q <= op[1];
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            dvs_q     <= cond_negate(divisor, dvs_neg);
            quo_q     <= cond_negate(dividend, dvd_neg);
            rem_q     <= '0;
            cnt       <= '0;
            // Special cases resolve immediately; the remainder for divide-by-zero
            // is the original (unsigned-magnitude-free) dividend.
            if (div_zero) begin
              result_q <= op[1] ? dividend : '1;
              state    <= DONE;
            end else if (sgn_ovf) begin
              result_q <= op[1] ? '0 : dividend;
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
              result_q <= rem_sel_q ? cond_negate(rem_nxt, neg_rem_q)
                                    : cond_negate(quo_nxt, neg_quo_q);
              state    <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall        = ((state == IDLE) & start & ~flush) | (state == CALC);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE) & ~flush;
  assign result       = result_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb_ex_div_sequencer
//   Directed-vector bench for ex_div_sequencer with hand-computed expectations.
module tb_ex_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  ex_div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the unit in IDLE. Presents the op, counts the
  // stall-high cycles and checks the result in the DONE cycle. With chain=1 start
  // stays high so the next call starts from the single IDLE cycle after DONE.
  task automatic do_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_stall, input bit chain);
    int n;
    start = 1'b1; op = o; dividend = a; divisor = b;
    #1;
    check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    check({tag, " stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, " valid"}, {31'b0, result_valid}, 32'd1);
    check({tag, " result"}, result, exp_res);
    if (!chain) begin
      start = 1'b0;
      @(negedge clk); #1;
      check({tag, " valid_drop"}, {31'b0, result_valid}, 32'd0);
      check({tag, " result_hold"}, result, exp_res);
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int vld_seen;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0;
    #2;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset valid", {31'b0, result_valid}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Normal ops.
    do_div("div 20/3",   2'b00, 32'd20,         32'd3, 32'd6,          33, 1'b0);
    do_div("rem -20/3",  2'b10, 32'hFFFF_FFEC,  32'd3, 32'hFFFF_FFFE,  33, 1'b0);
    do_div("div -20/3",  2'b00, 32'hFFFF_FFEC,  32'd3, 32'hFFFF_FFFA,  33, 1'b0);
    do_div("divu big",   2'b01, 32'hFFFF_FFFF,  32'd16, 32'h0FFF_FFFF, 33, 1'b0);

    // Special cases.
    do_div("divu 7/0",   2'b01, 32'd7,          32'd0, 32'hFFFF_FFFF,  1, 1'b0);
    do_div("remu 7/0",   2'b11, 32'd7,          32'd0, 32'd7,          1, 1'b0);
    do_div("div ovf",    2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    do_div("rem ovf",    2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,  1, 1'b0);

    // start and flush together in IDLE: no stall, stays IDLE.
    start = 1'b1; flush = 1'b1; op = 2'b00; dividend = 32'd20; divisor = 32'd3;
    #1;
    check("start+flush stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    check("start+flush busy", {31'b0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);

    // Flush in CALC cycle 10.
    start = 1'b1; op = 2'b00; dividend = 32'd20; divisor = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    check("flush pre busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush valid", {31'b0, result_valid}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush stall", {31'b0, stall}, 32'd0);
    vld_seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (result_valid) vld_seen++;
    end
    check("flush no valid", 32'(vld_seen), 32'd0);

    // Reset mid-CALC at cycle 5.
    @(negedge clk);
    start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd9;
    repeat (5) @(negedge clk);
    #1;
    check("pre-rst busy", {31'b0, busy}, 32'd1);
    rst = 1'b0; start = 1'b0;
    #1;
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst valid", {31'b0, result_valid}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back: the second call checks busy=0 in the one IDLE cycle between.
    do_div("b2b divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    do_div("b2b remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2,  33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
